nibble_serial_adder_ctrl: RTL

//  Multi-cycle controller that adds two WIDTH-bit operands using one external 4-bit ripple-carry adder.

---
 rtl/nibble_serial_adder_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder controller: drives an external 4-bit adder one nibble per cycle, LSB first.
// Optional macro SIGNED_OVF_EN adds an out_ovf port carrying two's-complement overflow of the result.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high, adder inputs parked at zero
// RUN   | one nibble per cycle through the external adder, carry chained in carry_reg
// DONE  | result presented with out_valid until out_ready
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef SIGNED_OVF_EN
  output logic             out_ovf,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic [3:0]       add_carry
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry_reg;
  logic [IDXW-1:0]  idx;
  logic             load, step;
  logic             unused_carry;

  // Lower per-bit carries are not needed by the controller.
  assign unused_carry = ^add_carry[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        add_a   = a_reg[4*idx +: 4];
        add_b   = b_reg[4*idx +: 4];
        add_cin = carry_reg;
        step    = 1'b1;
        if (idx == LAST) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      out_cout  <= 1'b0;
`ifdef SIGNED_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else if (load) begin
      a_reg     <= in_a;
      b_reg     <= in_b;
      carry_reg <= in_cin;
      idx       <= '0;
    end else if (step) begin
      sum_reg[4*idx +: 4] <= add_sum;
      carry_reg           <= add_carry[3];
      idx                 <= idx + 1'b1;
      if (idx == LAST) begin
        out_cout <= add_carry[3];
`ifdef SIGNED_OVF_EN
        // Carry into the MSB differing from carry out of it means signed overflow.
        out_ovf  <= add_carry[3] ^ add_carry[2];
`endif
      end
    end
  end

  assign out_sum = sum_reg;

endmodule
